// File: rtl/isr_requester.sv
// Host-side sequencer for one integer-square-root engine: takes an operand, runs the
// engine's reset/load handshake, waits for done (or times out) and returns the result.
module isr_requester #(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int LAT_W          = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_value,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_root,
  output logic [63:0]      resp_value,
  output logic             resp_error,
  output logic [LAT_W-1:0] resp_cycles,
  output logic             isr_reset,
  output logic [63:0]      isr_value,
  input  logic [31:0]      isr_result,
  input  logic             isr_done,
  output logic [15:0]      resp_count
);

  // A timeout beyond the counter's range degenerates to "saturated counter".
  localparam int LAT_MAX  = (2 ** LAT_W) - 1;
  localparam int TO_LAST  = (TIMEOUT_CYCLES - 1 > LAT_MAX) ? LAT_MAX : TIMEOUT_CYCLES - 1;
  localparam logic [LAT_W-1:0] TIMEOUT_LAST = LAT_W'(TO_LAST);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               isr_reset_q, isr_reset_d;
  logic [63:0]        isr_value_q, isr_value_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_root_q, resp_root_d;
  logic [63:0]        resp_value_q, resp_value_d;
  logic               resp_error_q, resp_error_d;
  logic [LAT_W-1:0]   resp_cycles_q, resp_cycles_d;
  logic [15:0]        resp_count_q, resp_count_d;
  logic [LAT_W-1:0]   lat_q, lat_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      isr_reset_q   <= 1'b1;
      isr_value_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_root_q   <= '0;
      resp_value_q  <= '0;
      resp_error_q  <= 1'b0;
      resp_cycles_q <= '0;
      resp_count_q  <= '0;
      lat_q         <= '0;
    end else begin
      state_q       <= state_d;
      isr_reset_q   <= isr_reset_d;
      isr_value_q   <= isr_value_d;
      resp_valid_q  <= resp_valid_d;
      resp_root_q   <= resp_root_d;
      resp_value_q  <= resp_value_d;
      resp_error_q  <= resp_error_d;
      resp_cycles_q <= resp_cycles_d;
      resp_count_q  <= resp_count_d;
      lat_q         <= lat_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    isr_reset_d   = isr_reset_q;
    isr_value_d   = isr_value_q;
    resp_valid_d  = resp_valid_q;
    resp_root_d   = resp_root_q;
    resp_value_d  = resp_value_q;
    resp_error_d  = resp_error_q;
    resp_cycles_d = resp_cycles_q;
    resp_count_d  = resp_count_q;
    lat_d         = lat_q;

    unique case (state_q)
      IDLE: begin
        isr_reset_d = 1'b1;
        if (req_valid) begin
          isr_value_d  = req_value;
          resp_value_d = req_value;
          lat_d        = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        // Engine samples isr_value at the end of this cycle while reset is still high.
        isr_reset_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (lat_q != '1) lat_d = lat_q + LAT_W'(1);
        if (isr_done) begin
          resp_root_d   = isr_result;
          resp_error_d  = 1'b0;
          resp_cycles_d = lat_q;
          isr_reset_d   = 1'b1;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end else if (lat_q >= TIMEOUT_LAST) begin
          resp_root_d   = '0;
          resp_error_d  = 1'b1;
          resp_cycles_d = lat_q;
          isr_reset_d   = 1'b1;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        isr_reset_d = 1'b1;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_count_d = resp_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_root   = resp_root_q;
  assign resp_value  = resp_value_q;
  assign resp_error  = resp_error_q;
  assign resp_cycles = resp_cycles_q;
  assign isr_reset   = isr_reset_q;
  assign isr_value   = isr_value_q;
  assign resp_count  = resp_count_q;

endmodule

// File: tb/tb_isr_requester.sv
// Directed + randomized bench for isr_requester with a behavioural stub engine
// whose done latency is chosen per transaction.
module tb_isr_requester;

  localparam int TO    = 16;
  localparam int LAT_W = 12;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [63:0]      req_value = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_root;
  logic [63:0]      resp_value;
  logic             resp_error;
  logic [LAT_W-1:0] resp_cycles;
  logic             isr_reset;
  logic [63:0]      isr_value;
  logic [31:0]      isr_result;
  logic             isr_done;
  logic [15:0]      resp_count;

  int checks = 0;
  int fails  = 0;
  int exp_count = 0;

  // stub engine state
  int          eng_lat = 1;
  int          eng_cnt = 0;
  logic [63:0] eng_val = '0;
  logic        eng_done = 1'b0;
  logic [31:0] eng_junk = '0;
  logic        spur = 1'b0;

  always #5 clock = ~clock;

  isr_requester #(.TIMEOUT_CYCLES(TO), .LAT_W(LAT_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_root(resp_root), .resp_value(resp_value), .resp_error(resp_error),
    .resp_cycles(resp_cycles),
    .isr_reset(isr_reset), .isr_value(isr_value),
    .isr_result(isr_result), .isr_done(isr_done),
    .resp_count(resp_count)
  );

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [63:0] r, t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[31:0];
  endfunction

  // Engine: loads while isr_reset is high, pulses done eng_lat cycles after release.
  always @(negedge clock) begin
    eng_junk = $urandom;
    if (isr_reset) begin
      eng_cnt  = 0;
      eng_val  = isr_value;
      eng_done = 1'b0;
    end else begin
      eng_cnt  = eng_cnt + 1;
      eng_done = (eng_cnt == eng_lat);
    end
  end

  assign isr_done   = eng_done | spur;
  assign isr_result = eng_done ? isqrt(eng_val) : eng_junk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [63:0] v, input int lat, input int hold);
    logic [31:0] er;
    logic        ee;
    int          ec, n;
    logic        ok;
    logic [31:0] s_root;
    logic [63:0] s_val;
    logic        s_err;
    logic [LAT_W-1:0] s_cyc;
    ee = (lat > TO);
    er = ee ? 32'd0 : isqrt(v);
    ec = ee ? TO - 1 : lat - 1;
    eng_lat = lat;
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_value = v;
    @(negedge clock);
    req_valid = 1'b0;
    req_value = {$urandom, $urandom};
    chk("load_isr_reset", isr_reset, 1);
    chk("load_isr_value", isr_value, v);
    chk("load_req_ready", req_ready, 0);
    n = 0;
    ok = 1'b1;
    @(negedge clock);
    while (!resp_valid && n < 200) begin
      if (isr_reset !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
      n++;
      @(negedge clock);
    end
    chk("wait_isr_reset_low", ok, 1);
    chk("wait_cycle_count", n, ec + 1);
    chk("resp_root", resp_root, er);
    chk("resp_value", resp_value, v);
    chk("resp_error", resp_error, ee);
    chk("resp_cycles", resp_cycles, ec);
    chk("resp_isr_reset", isr_reset, 1);
    s_root = resp_root; s_val = resp_value; s_err = resp_error; s_cyc = resp_cycles;
    req_valid = 1'b1;
    req_value = ~v;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      spur = (i == 0);
      @(negedge clock);
      spur = 1'b0;
      if (resp_valid !== 1'b1 || resp_root !== s_root || resp_value !== s_val ||
          resp_error !== s_err || resp_cycles !== s_cyc || req_ready !== 1'b0 ||
          isr_value !== v || isr_reset !== 1'b1 || resp_count !== 16'(exp_count)) ok = 1'b0;
    end
    chk("resp_hold_stable", ok, 1);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    exp_count++;
    chk("post_resp_valid", resp_valid, 0);
    chk("post_resp_count", resp_count, exp_count & 16'hFFFF);
    chk("post_no_same_cycle_accept", req_ready, 1);
    chk("post_isr_value_held", isr_value, v);
    $display("txn value=0x%0h lat=%0d hold=%0d root=0x%0h err=%0b cycles=%0d count=%0d",
             v, lat, hold, resp_root, resp_error, resp_cycles, resp_count);
  endtask

  initial begin
    logic [63:0] v;
    logic [31:0] r;
    // reset values while held in reset
    @(negedge clock);
    @(negedge clock);
    chk("rst_isr_reset", isr_reset, 1);
    chk("rst_isr_value", isr_value, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_root", resp_root, 0);
    chk("rst_resp_value", resp_value, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_resp_cycles", resp_cycles, 0);
    chk("rst_resp_count", resp_count, 0);
    chk("rst_req_ready", req_ready, 1);
    reset = 1'b1;
    @(negedge clock);

    // spurious done in IDLE is ignored
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    @(negedge clock);
    chk("idle_spur_resp_valid", resp_valid, 0);
    chk("idle_spur_req_ready", req_ready, 1);
    chk("idle_spur_count", resp_count, 0);

    run_txn(64'd16, 3, 0);
    run_txn(64'd15, 2, 1);
    run_txn(64'd0, 1, 0);
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 16, 2);   // done on the timeout cycle: done wins
    run_txn(64'd1_000_000, 5, 20);
    run_txn(64'd123, 1000, 1);                 // engine never answers
    run_txn(64'd456, 17, 0);                   // one cycle too late

    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0: v = 64'(r) * 64'(r);
        1: v = 64'(r) * 64'(r) - 64'd1;
        default: v = {$urandom, $urandom};
      endcase
      run_txn(v, $urandom_range(1, 20), $urandom_range(0, 3));
    end

    // async reset in the middle of WAIT
    eng_lat   = 10;
    req_valid = 1'b1;
    req_value = 64'd81;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_isr_reset", isr_reset, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_resp_count", resp_count, 0);
    chk("midrst_req_ready", req_ready, 1);
    exp_count = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_txn(64'd81, 4, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/isr_requester.md
Name: isr_requester

Overview:
- Host-side controller for the integer square root (ISR) engine. It accepts 64-bit operands over a valid/ready request channel and launches each one into the ISR engine using the engine's synchronous-reset load protocol.
- It waits for the engine's one-cycle done pulse and returns the 32-bit root, the echoed operand and the measured latency over a valid/ready response channel.
- Sits between the testbench/host pipeline and one ISR instance. It owns that instance's reset and value inputs exclusively.

Parameters:
- TIMEOUT_CYCLES, 2048, maximum WAIT cycles before the request is abandoned with an error (must be >= 2).
- LAT_W, 12, width of the latency counter and the resp_cycles field.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset: asserts immediately when low, deasserts synchronously to clock.
- req_valid  in  1  request operand valid.
- req_ready  out  1  requester can accept an operand.
- req_value  in  64  unsigned operand.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_root  out  32  floor(sqrt(operand)); 0 when resp_error=1.
- resp_value  out  64  echoed operand.
- resp_error  out  1  engine timed out.
- resp_cycles  out  LAT_W  WAIT cycles counted up to done, saturating at all-ones.
- isr_reset  out  1  drives the engine's active-high synchronous reset/load input.
- isr_value  out  64  drives the engine's value input; registered.
- isr_result  in  32  engine result; valid only in the cycle isr_done=1.
- isr_done  in  1  engine completion, a one-cycle pulse.
- resp_count  out  16  number of completed responses; wraps at 0xFFFF->0.

Behaviour:
- States: IDLE, LOAD, WAIT, RESP. All outputs are registered except req_ready, which is high exactly in IDLE.
- Reset values: state=IDLE, isr_reset=1, isr_value=0, resp_valid=0, resp_root=0, resp_value=0, resp_error=0, resp_cycles=0, resp_count=0.
- IDLE:
  - isr_reset=1, which parks the engine in its load state.
  - On req_valid&req_ready: isr_value<=req_value, resp_value<=req_value, latency counter<=0, go to LOAD.
- LOAD (exactly 1 cycle):
  - isr_reset stays 1 and isr_value is stable, so the engine samples the operand at the end of this cycle.
  - Go to WAIT; isr_reset<=0.
- WAIT:
  - isr_reset=0. The latency counter increments each cycle, saturating.
  - isr_done=1: resp_root<=isr_result, resp_error<=0, resp_cycles<=counter, isr_reset<=1, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: resp_root<=0, resp_error<=1, resp_cycles<=counter, isr_reset<=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins (no error).
- RESP:
  - resp_valid=1, isr_reset=1. All resp_* fields are held stable while resp_valid&!resp_ready.
  - On resp_valid&resp_ready: resp_valid<=0, resp_count<=resp_count+1, go to IDLE. A new request cannot be accepted in that same cycle; the earliest is the next cycle.
- isr_done outside WAIT is ignored; no state or output changes.
- isr_value is only updated in IDLE on accept and is held through LOAD/WAIT/RESP.
- Async reset mid-operation (any state): all registers return to reset values immediately and isr_reset goes to 1. The in-flight request is discarded with no response and no count increment.
- Throughput: one operand in flight. Minimum turnaround is 1 (IDLE) + 1 (LOAD) + engine latency + 1 (RESP, if resp_ready is high) cycles.

Test Plan:
- Reset low, then release; req_valid=1, req_value=16, resp_ready=1 -> exactly one response: resp_root=4, resp_value=16, resp_error=0, resp_count=1; isr_reset high for exactly 1 cycle after accept, then low until done.
- Back-to-back operands 15, 0, 0xFFFF_FFFF_FFFF_FFFF with req_valid held high -> roots 3, 0, 0xFFFF_FFFF in order; req_ready low from accept until RESP handshake; resp_count=3.
- Operand 1_000_000 with resp_ready held low for 20 cycles after resp_valid rises -> resp_root=1000 and all resp_* fields stable for all 20 cycles; a req_valid presented meanwhile is not accepted.
- Stub engine that never pulses done, TIMEOUT_CYCLES=16 -> resp_valid after 16 WAIT cycles with resp_error=1, resp_root=0, resp_cycles=15; isr_reset returns high.
- Stub engine pulsing isr_done in IDLE and in RESP -> no state change, no extra response, resp_count unchanged.
- Drive reset low for 1 cycle mid-WAIT on operand 81 -> immediate isr_reset=1, resp_valid=0, resp_count=0; a fresh request of 81 then returns resp_root=9.
